// File: rtl/mem_arbiter.sv
// Two-client (instruction/data) arbiter onto a single tagged memory port.
// Requests are granted round-robin. Returns are routed back to the client that owns their tag.
module mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  ic_command,
  input  logic [31:0] ic_addr,
  output logic [3:0]  ic_response,
  output logic [63:0] ic_data,
  output logic [3:0]  ic_tag,
  input  logic [1:0]  dc_command,
  input  logic [31:0] dc_addr,
  input  logic [63:0] dc_wdata,
  input  logic [1:0]  dc_size,
  output logic [3:0]  dc_response,
  output logic [63:0] dc_data,
  output logic [3:0]  dc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [1:0]  proc2mem_size,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [3:0]  ic_outstanding,
  output logic [3:0]  dc_outstanding,
  output logic        orphan_err
);

  localparam logic [1:0] BUS_NONE    = 2'd0;
  localparam logic [1:0] BUS_LOAD    = 2'd1;
  localparam logic [1:0] BUS_STORE   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  logic        rr_q, rr_d;
  logic [15:0] valid_q, valid_d;
  logic [15:0] owner_q, owner_d;   // owner bit: 0 = I-side, 1 = D-side
  logic [3:0]  ic_out_q, ic_out_d;
  logic [3:0]  dc_out_q, dc_out_d;
  logic        orphan_q, orphan_d;

  logic ic_req_s, dc_req_s, sel_d_s, accept_s, load_acc_s;
  logic ret_hit_s, ret_owner_s, ret_orphan_s;
  logic ic_inc_s, ic_dec_s, dc_inc_s, dc_dec_s;

  // Request decode, winner selection and memory-port drive
  always_comb begin
    ic_req_s         = (ic_command == BUS_LOAD);
    dc_req_s         = (dc_command == BUS_LOAD) || (dc_command == BUS_STORE);
    sel_d_s          = dc_req_s && (!ic_req_s || rr_q);
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 32'd0;
    proc2mem_data    = 64'd0;
    proc2mem_size    = SIZE_DOUBLE;
    if (sel_d_s) begin
      proc2mem_command = dc_command;
      proc2mem_addr    = dc_addr;
      proc2mem_data    = dc_wdata;
      proc2mem_size    = dc_size;
    end else if (ic_req_s) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = ic_addr;
    end else begin
      proc2mem_command = BUS_NONE;
    end
    accept_s    = (ic_req_s || dc_req_s) && (mem2proc_response != 4'd0);
    load_acc_s  = accept_s && (sel_d_s ? (dc_command == BUS_LOAD) : ic_req_s);
    ic_response = (ic_req_s && !sel_d_s) ? mem2proc_response : 4'd0;
    dc_response = sel_d_s ? mem2proc_response : 4'd0;
  end

  // Return routing through the owner table
  always_comb begin
    ret_hit_s    = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    ret_orphan_s = (mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag];
    ret_owner_s  = owner_q[mem2proc_tag];
    ic_tag  = 4'd0;
    ic_data = 64'd0;
    dc_tag  = 4'd0;
    dc_data = 64'd0;
    if (ret_hit_s && ret_owner_s) begin
      dc_tag  = mem2proc_tag;
      dc_data = mem2proc_data;
    end else if (ret_hit_s) begin
      ic_tag  = mem2proc_tag;
      ic_data = mem2proc_data;
    end else begin
      ic_tag = 4'd0;
    end
  end

  // Next-state: round-robin pointer, owner table, counters, orphan flag
  always_comb begin
    if (accept_s && ic_req_s && dc_req_s) begin
      rr_d = ~sel_d_s;
    end else begin
      rr_d = rr_q;
    end
    valid_d = valid_q;
    owner_d = owner_q;
    // Clear first so a same-cycle acceptance of the returning tag wins
    if (ret_hit_s) begin
      valid_d[mem2proc_tag] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (load_acc_s) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = sel_d_s;
    end else begin
      owner_d = owner_q;
    end
    valid_d[0] = 1'b0;
    owner_d[0] = 1'b0;

    ic_inc_s = load_acc_s && !sel_d_s;
    dc_inc_s = load_acc_s && sel_d_s;
    ic_dec_s = ret_hit_s && !ret_owner_s;
    dc_dec_s = ret_hit_s && ret_owner_s;
    if (ic_inc_s && !ic_dec_s && (ic_out_q != 4'd15)) begin
      ic_out_d = ic_out_q + 4'd1;
    end else if (ic_dec_s && !ic_inc_s && (ic_out_q != 4'd0)) begin
      ic_out_d = ic_out_q - 4'd1;
    end else begin
      ic_out_d = ic_out_q;
    end
    if (dc_inc_s && !dc_dec_s && (dc_out_q != 4'd15)) begin
      dc_out_d = dc_out_q + 4'd1;
    end else if (dc_dec_s && !dc_inc_s && (dc_out_q != 4'd0)) begin
      dc_out_d = dc_out_q - 4'd1;
    end else begin
      dc_out_d = dc_out_q;
    end
    orphan_d = orphan_q | ret_orphan_s;
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q     <= 1'b0;
      valid_q  <= 16'd0;
      owner_q  <= 16'd0;
      ic_out_q <= 4'd0;
      dc_out_q <= 4'd0;
      orphan_q <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      ic_out_q <= ic_out_d;
      dc_out_q <= dc_out_d;
      orphan_q <= orphan_d;
    end
  end

  assign ic_outstanding = ic_out_q;
  assign dc_outstanding = dc_out_q;
  assign orphan_err     = orphan_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a tag-ownership reference model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  ic_command, dc_command, dc_size;
  logic [31:0] ic_addr, dc_addr;
  logic [63:0] dc_wdata, mem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [3:0]  ic_response, ic_tag, dc_response, dc_tag;
  logic [63:0] ic_data, dc_data;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  ic_outstanding, dc_outstanding;
  logic        orphan_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_command(ic_command), .ic_addr(ic_addr),
    .ic_response(ic_response), .ic_data(ic_data), .ic_tag(ic_tag),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_size(dc_size),
    .dc_response(dc_response), .dc_data(dc_data), .dc_tag(dc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .ic_outstanding(ic_outstanding), .dc_outstanding(dc_outstanding),
    .orphan_err(orphan_err)
  );

  always #5 clock = ~clock;

  // Reference model: owner per tag (-1 none, 0 I-side, 1 D-side), preferred side, counters
  int m_own [16];
  int m_pref;
  int m_ico, m_dco;
  bit m_orph;
  int e_win;
  logic [3:0]  e_ic_resp, e_dc_resp, e_ic_tag, e_dc_tag;
  logic [63:0] e_ic_data, e_dc_data, e_data;
  logic [1:0]  e_cmd, e_size;
  logic [31:0] e_addr;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_own[i] = -1;
    m_pref = 0; m_ico = 0; m_dco = 0; m_orph = 1'b0;
  endtask

  task automatic model_eval();
    bit iw, dw;
    iw = (ic_command == 2'd1);
    dw = (dc_command == 2'd1) || (dc_command == 2'd2);
    if (iw && dw) e_win = m_pref;
    else if (iw)  e_win = 0;
    else if (dw)  e_win = 1;
    else          e_win = -1;
    e_cmd = 2'd0; e_addr = 32'd0; e_data = 64'd0; e_size = 2'd3;
    e_ic_resp = 4'd0; e_dc_resp = 4'd0;
    if (e_win == 0) begin
      e_cmd = 2'd1; e_addr = ic_addr; e_ic_resp = mem2proc_response;
    end
    if (e_win == 1) begin
      e_cmd = dc_command; e_addr = dc_addr; e_data = dc_wdata; e_size = dc_size;
      e_dc_resp = mem2proc_response;
    end
    e_ic_tag = 4'd0; e_ic_data = 64'd0; e_dc_tag = 4'd0; e_dc_data = 64'd0;
    if (mem2proc_tag != 4'd0 && m_own[mem2proc_tag] == 0) begin
      e_ic_tag = mem2proc_tag; e_ic_data = mem2proc_data;
    end
    if (mem2proc_tag != 4'd0 && m_own[mem2proc_tag] == 1) begin
      e_dc_tag = mem2proc_tag; e_dc_data = mem2proc_data;
    end
  endtask

  task automatic model_commit();
    int t, old, di, dd;
    bit acc, ld, both;
    model_eval();
    t    = int'(mem2proc_tag);
    old  = (t != 0) ? m_own[t] : -1;
    both = (ic_command == 2'd1) && ((dc_command == 2'd1) || (dc_command == 2'd2));
    acc  = (e_win >= 0) && (mem2proc_response != 4'd0);
    ld   = acc && (e_cmd == 2'd1);
    if (acc && both) m_pref = 1 - e_win;
    di = ((ld && e_win == 0) ? 1 : 0) - ((old == 0) ? 1 : 0);
    dd = ((ld && e_win == 1) ? 1 : 0) - ((old == 1) ? 1 : 0);
    m_ico = (m_ico + di > 15) ? 15 : ((m_ico + di < 0) ? 0 : m_ico + di);
    m_dco = (m_dco + dd > 15) ? 15 : ((m_dco + dd < 0) ? 0 : m_dco + dd);
    if (t != 0 && old < 0) m_orph = 1'b1;
    if (t != 0 && old >= 0) m_own[t] = -1;
    if (ld) m_own[mem2proc_response] = e_win;
  endtask

  task automatic idle();
    ic_command = 2'd0; ic_addr = 32'd0;
    dc_command = 2'd0; dc_addr = 32'd0; dc_wdata = 64'd0; dc_size = 2'd0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    ic_command = 2'd1; mem2proc_response = 4'd9;
    settle();
    tick();
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (ic_outstanding !== 4'd0 || dc_outstanding !== 4'd0 || orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ico=%0d dco=%0d orph=%0b exp 0 0 0", ic_outstanding, dc_outstanding, orphan_err);
    end
    idle();
    #1;
    checks++;
    if (proc2mem_command !== 2'd0 || proc2mem_addr !== 32'd0 || proc2mem_data !== 64'd0 || proc2mem_size !== 2'd3) begin
      errors++;
      $display("FAIL idle_port cmd=%0d addr=%h data=%h size=%0d exp 0 0 0 3", proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size);
    end
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_load();
    do_reset();
    ic_command = 2'd1; ic_addr = 32'h100; mem2proc_response = 4'd3;
    settle();
    checks++;
    if (ic_response !== 4'd3 || dc_response !== 4'd0 || proc2mem_command !== 2'd1 ||
        proc2mem_addr !== 32'h100 || proc2mem_size !== 2'd3 || proc2mem_data !== 64'd0) begin
      errors++;
      $display("FAIL s1_accept icr=%0d dcr=%0d cmd=%0d addr=%h size=%0d exp 3 0 1 100 3", ic_response, dc_response, proc2mem_command, proc2mem_addr, proc2mem_size);
    end
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (ic_outstanding !== 4'd1) begin
        errors++;
        $display("FAIL s1_pending ico=%0d exp 1", ic_outstanding);
      end
      tick();
    end
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD;
    settle();
    checks++;
    if (ic_tag !== 4'd3 || ic_data !== 64'hDEAD || dc_tag !== 4'd0 || dc_data !== 64'd0) begin
      errors++;
      $display("FAIL s1_return ict=%0d icd=%h dct=%0d exp 3 dead 0", ic_tag, ic_data, dc_tag);
    end
    tick();
    idle();
    settle();
    checks++;
    if (ic_outstanding !== 4'd0 || orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL s1_done ico=%0d orph=%0b exp 0 0", ic_outstanding, orphan_err);
    end
  endtask

  task automatic test_alternation();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ic_command = 2'd1; dc_command = 2'd1;
      ic_addr = 32'h1000 + 32'(i); dc_addr = 32'h2000 + 32'(i);
      mem2proc_response = 4'(i + 1);
      settle();
      checks++;
      if (ic_response !== ((i % 2 == 0) ? 4'(i + 1) : 4'd0) ||
          dc_response !== ((i % 2 == 1) ? 4'(i + 1) : 4'd0)) begin
        errors++;
        $display("FAIL alternate step %0d icr=%0d dcr=%0d", i, ic_response, dc_response);
      end
      tick();
    end
    idle();
    settle();
    checks++;
    if (ic_outstanding !== 4'd4 || dc_outstanding !== 4'd4) begin
      errors++;
      $display("FAIL alternate_count ico=%0d dco=%0d exp 4 4", ic_outstanding, dc_outstanding);
    end
  endtask

  task automatic test_reject();
    do_reset();
    ic_command = 2'd1; dc_command = 2'd1; ic_addr = 32'h40; dc_addr = 32'h80;
    mem2proc_response = 4'd1;
    settle();
    tick();
    for (int i = 0; i < 3; i++) begin
      mem2proc_response = (i == 2) ? 4'd4 : 4'd0;
      settle();
      checks++;
      if (proc2mem_addr !== 32'h80 || ic_response !== 4'd0 || dc_response !== mem2proc_response) begin
        errors++;
        $display("FAIL reject step %0d addr=%h icr=%0d dcr=%0d exp 80 0 %0d", i, proc2mem_addr, ic_response, dc_response, mem2proc_response);
      end
      tick();
    end
    mem2proc_response = 4'd5;
    settle();
    checks++;
    if (ic_response !== 4'd5 || dc_response !== 4'd0) begin
      errors++;
      $display("FAIL reject_after icr=%0d dcr=%0d exp 5 0", ic_response, dc_response);
    end
    tick();
  endtask

  task automatic test_store_orphan();
    do_reset();
    dc_command = 2'd2; dc_addr = 32'h300; dc_wdata = 64'h1234; dc_size = 2'd2;
    mem2proc_response = 4'd5;
    settle();
    checks++;
    if (proc2mem_command !== 2'd2 || proc2mem_data !== 64'h1234 || proc2mem_size !== 2'd2 || dc_response !== 4'd5) begin
      errors++;
      $display("FAIL store_issue cmd=%0d data=%h size=%0d dcr=%0d exp 2 1234 2 5", proc2mem_command, proc2mem_data, proc2mem_size, dc_response);
    end
    tick();
    idle();
    mem2proc_tag = 4'd5; mem2proc_data = 64'h77;
    settle();
    checks++;
    if (ic_tag !== 4'd0 || dc_tag !== 4'd0 || dc_outstanding !== 4'd0 || orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL store_return ict=%0d dct=%0d dco=%0d orph=%0b exp 0 0 0 0", ic_tag, dc_tag, dc_outstanding, orphan_err);
    end
    tick();
    idle();
    settle();
    checks++;
    if (orphan_err !== 1'b1) begin
      errors++;
      $display("FAIL store_orphan orph=%0b exp 1", orphan_err);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    ic_command = 2'd1; mem2proc_response = 4'd7;
    settle();
    tick();
    idle();
    settle();
    checks++;
    if (ic_outstanding !== 4'd1) begin
      errors++;
      $display("FAIL midflight_pending ico=%0d exp 1", ic_outstanding);
    end
    do_reset();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h5;
    settle();
    checks++;
    if (ic_tag !== 4'd0 || ic_outstanding !== 4'd0) begin
      errors++;
      $display("FAIL midflight_return ict=%0d ico=%0d exp 0 0", ic_tag, ic_outstanding);
    end
    tick();
    idle();
    settle();
    checks++;
    if (orphan_err !== 1'b1 || ic_outstanding !== 4'd0 || dc_outstanding !== 4'd0) begin
      errors++;
      $display("FAIL midflight_orphan orph=%0b ico=%0d dco=%0d exp 1 0 0", orphan_err, ic_outstanding, dc_outstanding);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    ic_command = 2'd1; mem2proc_response = 4'd2;
    settle();
    tick();
    idle();
    dc_command = 2'd1; dc_addr = 32'h500; mem2proc_response = 4'd2;
    mem2proc_tag = 4'd2; mem2proc_data = 64'hAAAA;
    settle();
    checks++;
    if (ic_tag !== 4'd2 || ic_data !== 64'hAAAA || dc_tag !== 4'd0 || dc_response !== 4'd2) begin
      errors++;
      $display("FAIL same_cycle ict=%0d icd=%h dct=%0d dcr=%0d exp 2 aaaa 0 2", ic_tag, ic_data, dc_tag, dc_response);
    end
    tick();
    idle();
    mem2proc_tag = 4'd2; mem2proc_data = 64'hBBBB;
    settle();
    checks++;
    if (dc_tag !== 4'd2 || dc_data !== 64'hBBBB || ic_tag !== 4'd0 || ic_outstanding !== 4'd0 || dc_outstanding !== 4'd1) begin
      errors++;
      $display("FAIL same_cycle_next dct=%0d dcd=%h ict=%0d ico=%0d dco=%0d exp 2 bbbb 0 0 1", dc_tag, dc_data, ic_tag, ic_outstanding, dc_outstanding);
    end
    tick();
    idle();
    settle();
    checks++;
    if (dc_outstanding !== 4'd0 || orphan_err !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_done dco=%0d orph=%0b exp 0 0", dc_outstanding, orphan_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ic_command = 2'd3; dc_command = 2'd1; mem2proc_response = 4'((i % 15) + 1);
      settle();
      tick();
    end
    idle();
    settle();
    checks++;
    if (dc_outstanding !== 4'd15 || ic_outstanding !== 4'd0) begin
      errors++;
      $display("FAIL saturate dco=%0d ico=%0d exp 15 0", dc_outstanding, ic_outstanding);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ic_command = 2'($urandom_range(0, 3));
      dc_command = 2'($urandom_range(0, 3));
      ic_addr = $urandom; dc_addr = $urandom;
      dc_wdata = {$urandom, $urandom}; dc_size = 2'($urandom_range(0, 3));
      mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2proc_tag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2proc_data = {$urandom, $urandom};
      settle();
      model_eval();
      checks++;
      if (proc2mem_command !== e_cmd || proc2mem_addr !== e_addr || proc2mem_data !== e_data || proc2mem_size !== e_size) begin
        errors++;
        $display("FAIL rnd_port cyc %0d got %0d/%h/%h/%0d exp %0d/%h/%h/%0d", c, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size, e_cmd, e_addr, e_data, e_size);
      end
      checks++;
      if (ic_response !== e_ic_resp || dc_response !== e_dc_resp) begin
        errors++;
        $display("FAIL rnd_resp cyc %0d got %0d/%0d exp %0d/%0d", c, ic_response, dc_response, e_ic_resp, e_dc_resp);
      end
      checks++;
      if (ic_tag !== e_ic_tag || ic_data !== e_ic_data || dc_tag !== e_dc_tag || dc_data !== e_dc_data) begin
        errors++;
        $display("FAIL rnd_return cyc %0d got %0d/%h %0d/%h exp %0d/%h %0d/%h", c, ic_tag, ic_data, dc_tag, dc_data, e_ic_tag, e_ic_data, e_dc_tag, e_dc_data);
      end
      checks++;
      if (ic_outstanding !== 4'(m_ico) || dc_outstanding !== 4'(m_dco) || orphan_err !== m_orph) begin
        errors++;
        $display("FAIL rnd_state cyc %0d got %0d/%0d/%0b exp %0d/%0d/%0b", c, ic_outstanding, dc_outstanding, orphan_err, m_ico, m_dco, m_orph);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    model_reset();
    #1;
    test_reset();
    test_single_load();
    test_alternation();
    test_reject();
    test_store_orphan();
    test_reset_midflight();
    test_same_cycle();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
